// File: rtl/imem_loader.sv
// Instruction-memory loader: consumes a length-prefixed byte stream and writes
// big-endian 32-bit words to consecutive instruction-memory word addresses.
module imem_loader #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEN  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_r;
   logic [1:0]    byte_idx_r;
   logic [23:0]   part_r;
   logic [7:0]    len_hi_r;
   logic [15:0]   len_r;
   logic [15:0]   word_cnt_r;

   logic          hs_s;
   logic [15:0]   n_s;
   logic          n_zero_s;
   logic          n_big_s;
   logic          last_word_s;

   // Handshake decode and length checks on the byte currently presented
   always_comb begin
      hs_s        = in_valid & in_ready;
      n_s         = {len_hi_r, in_byte};
      n_zero_s    = (n_s == 16'd0);
      n_big_s     = ({16'd0, n_s} > (32'd1 << ADDR_W));
      last_word_s = (word_cnt_r == (len_r - 16'd1));
   end

   // Load sequencer with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         byte_idx_r <= 2'd0;
         part_r     <= 24'd0;
         len_hi_r   <= 8'd0;
         len_r      <= 16'd0;
         word_cnt_r <= 16'd0;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 32'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r    <= LEN;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  byte_idx_r <= 2'd0;
                  word_cnt_r <= 16'd0;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
               end else begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
               end
            end
            LEN: begin
               if (hs_s) begin
                  if (byte_idx_r == 2'd0) begin
                     len_hi_r   <= in_byte;
                     byte_idx_r <= 2'd1;
                  end else begin
                     byte_idx_r <= 2'd0;
                     len_r      <= n_s;
                     if (n_zero_s) begin
                        state_r  <= DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                     end else if (n_big_s) begin
                        state_r  <= IDLE;
                        err      <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                     end else begin
                        state_r <= DATA;
                     end
                  end
               end
            end
            DATA: begin
               if (hs_s) begin
                  byte_idx_r <= byte_idx_r + 2'd1;
                  if (byte_idx_r == 2'd3) begin
                     wr_en      <= 1'b1;
                     wr_addr    <= ADDR_W'(word_cnt_r);
                     wr_data    <= {part_r, in_byte};
                     word_cnt_r <= word_cnt_r + 16'd1;
                     // Final write cycle is spent in DONE with busy still high
                     if (last_word_s) begin
                        state_r  <= DONE;
                        in_ready <= 1'b0;
                     end
                  end else begin
                     part_r <= {part_r[15:0], in_byte};
                  end
               end
            end
            DONE: begin
               state_r  <= IDLE;
               done     <= 1'b1;
               busy     <= 1'b0;
               in_ready <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader (ADDR_W=4 so length limits are reachable).
module tb_imem_loader;

   localparam int AW = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            hs;
      logic          busy;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [7:0]    in_byte;
   logic          in_valid;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          busy;
   logic          done;
   logic          err;

   int  errors = 0;
   int  checks = 0;
   int  hs_cnt = 0;
   wr_t obs_q[$];
   int  hs_base;
   int  obs_base;

   imem_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte),
      .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Count accepted bytes
   always @(posedge clk) if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;

   // Record every write with the number of bytes accepted so far
   always @(negedge clk) begin
      if (wr_en) obs_q.push_back('{addr: wr_addr, data: wr_data, hs: hs_cnt, busy: busy});
   end

   // Reference model: length prefix and big-endian words straight from the byte stream
   function automatic int exp_n(input logic [7:0] b[$]);
      return int'(b[0]) * 256 + int'(b[1]);
   endfunction

   function automatic int exp_writes(input logic [7:0] b[$]);
      int n = exp_n(b);
      return (n > (1 << AW)) ? 0 : n;
   endfunction

   function automatic logic [31:0] exp_word(input logic [7:0] b[$], input int k);
      return {b[2+4*k], b[3+4*k], b[4+4*k], b[5+4*k]};
   endfunction

   function automatic void make_stream(input int n, output logic [7:0] b[$]);
      b = {};
      b.push_back(8'(n >> 8));
      b.push_back(8'(n));
      if (n <= (1 << AW)) for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
   endfunction

   task automatic run_stream(input logic [7:0] b[$], input int pct, input bit noise);
      int  i = 0;
      int  budget = 0;
      bit  pend;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hs_base  = hs_cnt;
      obs_base = obs_q.size();
      while (i < b.size() && budget < 4000) begin
         in_byte  = b[i];
         in_valid = ($urandom_range(99) < pct);
         start    = noise ? 1'($urandom_range(1)) : 1'b0;
         pend     = in_valid && in_ready;
         @(posedge clk); #1;
         if (pend) i++;
         budget++;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_byte  = 8'hA5;
      if (i < b.size()) begin
         errors++;
         $display("FAIL stream_timeout: accepted %0d bytes, required %0d", i, b.size());
      end
      checks++;
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
      #12;
      checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b, required all 0",
                  in_ready, wr_en, wr_addr, wr_data, busy, done, err);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_byte = 8'h55;
      repeat (5) @(posedge clk);
      #1; in_valid = 1'b0;
      checks++;
      if (hs_cnt !== 0 || obs_q.size() !== 0) begin
         errors++;
         $display("FAIL reset_no_activity: got hs=%0d writes=%0d, required 0 and 0", hs_cnt, obs_q.size());
      end
   endtask

   task automatic test_basic();
      logic [7:0]  b[$] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
      logic [31:0] want[2] = '{32'hDEADBEEF, 32'h01234567};
      run_stream(b, 100, 1'b0);
      checks++;
      if (obs_q.size() - obs_base !== 2) begin
         errors++;
         $display("FAIL basic_count: got %0d writes, required 2", obs_q.size() - obs_base);
      end else begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_q[obs_base+k].addr !== AW'(k) || obs_q[obs_base+k].data !== want[k] ||
                obs_q[obs_base+k].hs !== hs_base + 2 + 4*(k+1) || obs_q[obs_base+k].busy !== 1'b1) begin
               errors++;
               $display("FAIL basic_write%0d: got a=%0h d=%h hs=%0d busy=%b, required a=%0h d=%h hs=%0d busy=1",
                        k, obs_q[obs_base+k].addr, obs_q[obs_base+k].data, obs_q[obs_base+k].hs - hs_base,
                        obs_q[obs_base+k].busy, k, want[k], 2 + 4*(k+1));
            end
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || hs_cnt - hs_base !== 10) begin
         errors++;
         $display("FAIL basic_status: got done=%b busy=%b err=%b hs=%0d, required 1 0 0 10",
                  done, busy, err, hs_cnt - hs_base);
      end
   endtask

   task automatic test_zero();
      logic [7:0] b[$] = '{8'h00, 8'h00};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_byte = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_done_cycle: got done=%b busy=%b rdy=%b, required 0 0 0", done, busy, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || wr_en !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: got done=%b err=%b we=%b, required 1 0 0", done, err, wr_en);
      end
      obs_base = obs_q.size();
      run_stream(b, 60, 1'b0);
      checks++;
      if (obs_q.size() !== obs_base || done !== 1'b1) begin
         errors++;
         $display("FAIL zero_no_write: got writes=%0d done=%b, required 0 1", obs_q.size() - obs_base, done);
      end
   endtask

   task automatic test_len_limits();
      logic [7:0] b[$];
      make_stream(17, b);
      run_stream(b, 100, 1'b0);
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
          obs_q.size() !== obs_base || hs_cnt - hs_base !== 2) begin
         errors++;
         $display("FAIL len_too_big: got err=%b done=%b busy=%b rdy=%b writes=%0d hs=%0d, required 1 0 0 0 0 2",
                  err, done, busy, in_ready, obs_q.size() - obs_base, hs_cnt - hs_base);
      end
      make_stream(16, b);
      run_stream(b, 100, 1'b0);
      checks++;
      if (obs_q.size() - obs_base !== 16 || err !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL len_max: got writes=%0d err=%b done=%b, required 16 0 1", obs_q.size() - obs_base, err, done);
      end else begin
         checks++;
         if (obs_q[obs_base+15].addr !== 4'hF || obs_q[obs_base+15].data !== exp_word(b, 15)) begin
            errors++;
            $display("FAIL len_max_last: got a=%0h d=%h, required a=f d=%h",
                     obs_q[obs_base+15].addr, obs_q[obs_base+15].data, exp_word(b, 15));
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] b[$] = '{8'h00, 8'h01, 8'hC0, 8'hFF, 8'hEE, 8'h01};
      int toggle = 0;
      int budget = 0;
      int i = 0;
      bit pend;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; hs_base = hs_cnt; obs_base = obs_q.size();
      while (i < b.size() && budget < 100) begin
         in_byte = b[i]; in_valid = 1'(toggle); toggle ^= 1;
         pend = in_valid && in_ready;
         @(posedge clk); #1;
         if (pend) i++;
         budget++;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() - obs_base !== 1 || hs_cnt - hs_base !== 6) begin
         errors++;
         $display("FAIL stall_count: got writes=%0d hs=%0d, required 1 6", obs_q.size() - obs_base, hs_cnt - hs_base);
      end else begin
         checks++;
         if (obs_q[obs_base].addr !== 4'h0 || obs_q[obs_base].data !== 32'hC0FFEE01) begin
            errors++;
            $display("FAIL stall_word: got a=%0h d=%h, required a=0 d=c0ffee01",
                     obs_q[obs_base].addr, obs_q[obs_base].data);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] pre[4] = '{8'h00, 8'h01, 8'hDE, 8'hAD};
      logic [7:0] b[$] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_byte = pre[i]; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b, required all 0",
                  in_ready, wr_en, wr_addr, wr_data, busy, done, err);
      end
      @(negedge clk); rst_n = 1'b1;
      obs_base = obs_q.size(); hs_base = hs_cnt;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() !== obs_base || hs_cnt !== hs_base) begin
         errors++;
         $display("FAIL midreset_quiet: got writes=%0d hs=%0d, required 0 0", obs_q.size() - obs_base, hs_cnt - hs_base);
      end
      in_valid = 1'b0;
      run_stream(b, 100, 1'b0);
      checks++;
      if (obs_q.size() - obs_base !== 1 || obs_q[obs_q.size()-1].addr !== 4'h0 ||
          obs_q[obs_q.size()-1].data !== 32'h00000013) begin
         errors++;
         $display("FAIL midreset_restart: got writes=%0d last d=%h, required 1 write a=0 d=00000013",
                  obs_q.size() - obs_base, obs_q[obs_q.size()-1].data);
      end
   endtask

   task automatic test_random(input int iters, input bit noise, input string tag);
      logic [7:0] b[$];
      int n, w;
      for (int it = 0; it < iters; it++) begin
         n = $urandom_range(18);
         make_stream(n, b);
         run_stream(b, $urandom_range(100, 30), noise);
         w = exp_writes(b);
         checks++;
         if (obs_q.size() - obs_base !== w || hs_cnt - hs_base !== b.size() ||
             done !== (exp_n(b) <= (1 << AW)) || err !== (exp_n(b) > (1 << AW)) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s%0d_status: N=%0d got writes=%0d hs=%0d done=%b err=%b busy=%b, required %0d %0d %b %b 0",
                     tag, it, n, obs_q.size() - obs_base, hs_cnt - hs_base, done, err, busy,
                     w, b.size(), exp_n(b) <= (1 << AW), exp_n(b) > (1 << AW));
         end
         for (int k = 0; k < w && obs_base + k < obs_q.size(); k++) begin
            checks++;
            if (obs_q[obs_base+k].addr !== AW'(k) || obs_q[obs_base+k].data !== exp_word(b, k) ||
                obs_q[obs_base+k].hs !== hs_base + 2 + 4*(k+1) || obs_q[obs_base+k].busy !== 1'b1) begin
               errors++;
               $display("FAIL %s%0d_word%0d: got a=%0h d=%h hs=%0d busy=%b, required a=%0h d=%h hs=%0d busy=1",
                        tag, it, k, obs_q[obs_base+k].addr, obs_q[obs_base+k].data,
                        obs_q[obs_base+k].hs - hs_base, obs_q[obs_base+k].busy, k, exp_word(b, k), 2 + 4*(k+1));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_len_limits();
      test_stall();
      test_reset_mid();
      test_random(3, 1'b1, "start_noise");
      test_random(12, 1'b0, "rand");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, instruction-memory word-address width.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  input  1  request to begin a program load.
REQ-005 SHALL provide port in_byte  input  8  incoming load-stream byte.
REQ-006 SHALL provide port in_valid  input  1  in_byte valid.
REQ-007 SHALL provide port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL provide port wr_en  output  1  instruction-memory write strobe.
REQ-009 SHALL provide port wr_addr  output  ADDR_W  word address of write.
REQ-010 SHALL provide port wr_data  output  32  instruction word to write.
REQ-011 SHALL provide port busy  output  1  load in progress; CPU fetch held while high.
REQ-012 SHALL provide port done  output  1  sticky: last load completed successfully.
REQ-013 SHALL provide port err  output  1  sticky: last load rejected.

Function
REQ-014 SHALL implement states IDLE, LEN, DATA, DONE.
REQ-015 SHALL define a byte handshake as in_valid=1 and in_ready=1 at a rising edge; in_ready SHALL be 1 exactly in LEN and DATA.
REQ-016 IDLE: start=1 SHALL move to LEN and clear done, err, byte index, word counter on the same edge.
REQ-017 LEN: SHALL accept two bytes, MSB first, forming 16-bit word count N.
REQ-018 On second LEN byte: N=0 SHALL go to DONE with no writes; N > 2^ADDR_W SHALL set err and go to IDLE with no writes; otherwise go to DATA.
REQ-019 DATA: SHALL accept bytes MSB first (first byte -> wr_data[31:24]); the 4th byte completes a word.
REQ-020 wr_en SHALL pulse high for exactly one cycle, in the cycle after the 4th-byte handshake, with wr_addr = word index (0,1,...,N-1) and wr_data = assembled word, both stable during that cycle.
REQ-021 in_ready SHALL stay high during the wr_en cycle; sustained throughput SHALL be one byte per cycle.
REQ-022 After the write of word N-1 is issued, state SHALL go to DONE; no further bytes accepted.
REQ-023 DONE: SHALL last one cycle, set done=1, then return to IDLE; done SHALL hold until next accepted start.
REQ-024 busy SHALL be 1 in LEN and DATA and during the final wr_en cycle, else 0.
REQ-025 start while not in IDLE SHALL be ignored.
REQ-026 Stalls (in_valid=0) SHALL freeze byte index, partial word and counters indefinitely.
REQ-027 wr_addr SHALL never exceed 2^ADDR_W-1; word counter SHALL not wrap within a load.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
REQ-029 Reset mid-load SHALL discard any partial word and issue no further writes; memory contents already written are not the loader's concern.
REQ-030 After rst_n rises, no handshake or write SHALL occur until start is asserted.

Verification
REQ-031 start; stream 00 02 DE AD BE EF 01 23 45 67 with in_valid=1 -> wr_en at addr 0 data DEADBEEF, addr 1 data 01234567, done=1, busy=0, err=0.
REQ-032 start; stream 00 00 -> no wr_en, DONE one cycle later, done=1.
REQ-033 ADDR_W=4; start; stream 00 11 -> err=1, done=0, IDLE, no wr_en, in_ready=0.
REQ-034 N=1, in_valid toggled 1/0 every cycle -> single write addr 0 with correct word, bytes never duplicated or dropped.
REQ-035 Assert rst_n=0 after 2 of 4 data bytes, release, restart with N=1 word 0000_0013 -> single write addr 0 data 00000013, no stale bytes.
REQ-036 start pulsed during DATA -> ignored; load completes with original N and addresses.
